// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and default widths for the MEM->WB pipeline boundary
package core_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              is_load;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mem_data;
  } wb_bundle_t;

endpackage

// File: rtl/mem_wait_ctrl.sv
// rtl/mem_wait_ctrl.sv - load-wait FSM: stall, wait counter, sticky timeout and capture strobes
module mem_wait_ctrl
  import core_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic freeze_i,
  input  logic flush_i,
  input  logic mem_rd_en_i,
  input  logic mem_ready_i,
  output logic stall_o,
  output logic fields_we_o,
  output logic mem_we_o,
  output logic accept_o,
  output logic mem_timeout_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  wb_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             start_wait;

  assign start_wait = (state_q == IDLE) && mem_rd_en_i && !mem_ready_i && !flush_i && !freeze_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!freeze_i) begin
      unique case (state_q)
        IDLE: begin
          if (start_wait) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        WAIT: begin
          // A flush aborts the read even when the data arrives in the same cycle
          if (flush_i || mem_ready_i) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
    timeout_d = timeout_q | (cnt_d == CNT_MAX);
  end

  always_comb begin
    stall_o     = 1'b0;
    fields_we_o = 1'b0;
    mem_we_o    = 1'b0;
    accept_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_o     = start_wait;
        fields_we_o = !freeze_i;
        accept_o    = !freeze_i && !flush_i && !start_wait;
      end
      WAIT: begin
        stall_o  = freeze_i || (!flush_i && !mem_ready_i);
        mem_we_o = !freeze_i && !flush_i && mem_ready_i;
        accept_o = !freeze_i && !flush_i && mem_ready_i;
      end
    endcase
    if (!rst) stall_o = 1'b0;
  end

  assign mem_timeout_o = timeout_q;

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM->WB pipeline register and writeback mux; WB_FORWARD_EN adds early-forward outputs
module mem_wb_stage
  import core_pkg::*;
#(
  parameter int DATA_W   = core_pkg::DATA_W,
  parameter int REG_AW   = core_pkg::REG_AW,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ready_i,
  input  logic [REG_AW-1:0] dest_i,
  input  logic              wb_en_i,
  input  logic              mem_rd_en_i,
  output logic              stall_o,
  output logic              wb_en_o,
  output logic [REG_AW-1:0] wb_dest_o,
  output logic [DATA_W-1:0] wb_value_o,
  output logic              mem_timeout_o
`ifdef WB_FORWARD_EN
  ,
  output logic              fwd_valid_o,
  output logic [REG_AW-1:0] fwd_dest_o,
  output logic [DATA_W-1:0] fwd_value_o
`endif
);

  // The bundle is sized by the package defaults; DATA_W/REG_AW must match them
  wb_bundle_t pipe_q, pipe_d;
  logic       fields_we, mem_we, accept;

  mem_wait_ctrl #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctrl (
    .clk           (clk),
    .rst           (rst),
    .freeze_i      (freeze_i),
    .flush_i       (flush_i),
    .mem_rd_en_i   (mem_rd_en_i),
    .mem_ready_i   (mem_ready_i),
    .stall_o       (stall_o),
    .fields_we_o   (fields_we),
    .mem_we_o      (mem_we),
    .accept_o      (accept),
    .mem_timeout_o (mem_timeout_o)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  always_comb begin
    pipe_d = pipe_q;
    if (fields_we) begin
      pipe_d.wb_en    = wb_en_i;
      pipe_d.is_load  = mem_rd_en_i;
      pipe_d.dest     = dest_i;
      pipe_d.alu_res  = alu_res_i;
      pipe_d.mem_data = mem_data_i;
    end
    // Completing a stalled load only refreshes the data; control was latched on entry
    if (mem_we) pipe_d.mem_data = mem_data_i;
    if (!freeze_i) pipe_d.valid = accept;
  end

  assign wb_en_o    = pipe_q.valid & pipe_q.wb_en;
  assign wb_dest_o  = pipe_q.dest;
  assign wb_value_o = pipe_q.is_load ? pipe_q.mem_data : pipe_q.alu_res;

`ifdef WB_FORWARD_EN
  assign fwd_valid_o = accept & wb_en_i;
  assign fwd_dest_o  = dest_i;
  assign fwd_value_o = mem_rd_en_i ? mem_data_i : alu_res_i;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze_i = 1'b0, flush_i = 1'b0, mem_ready_i = 1'b0;
  logic        wb_en_i = 1'b0, mem_rd_en_i = 1'b0;
  logic [31:0] alu_res_i = '0, mem_data_i = '0;
  logic [3:0]  dest_i = '0;
  logic        stall_o, wb_en_o, mem_timeout_o;
  logic [3:0]  wb_dest_o;
  logic [31:0] wb_value_o;
`ifdef WB_FORWARD_EN
  logic        fwd_valid_o;
  logic [3:0]  fwd_dest_o;
  logic [31:0] fwd_value_o;
`endif

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] value;
  } wr_t;

  wr_t  sb[$];
  logic exp_wr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_wb_stage #(.DATA_W(32), .REG_AW(4), .MAX_WAIT(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .freeze_i      (freeze_i),
    .flush_i       (flush_i),
    .alu_res_i     (alu_res_i),
    .mem_data_i    (mem_data_i),
    .mem_ready_i   (mem_ready_i),
    .dest_i        (dest_i),
    .wb_en_i       (wb_en_i),
    .mem_rd_en_i   (mem_rd_en_i),
    .stall_o       (stall_o),
    .wb_en_o       (wb_en_o),
    .wb_dest_o     (wb_dest_o),
    .wb_value_o    (wb_value_o),
    .mem_timeout_o (mem_timeout_o)
`ifdef WB_FORWARD_EN
    ,
    .fwd_valid_o   (fwd_valid_o),
    .fwd_dest_o    (fwd_dest_o),
    .fwd_value_o   (fwd_value_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] mem, input logic [3:0] dest,
                       input logic wb, input logic rd, input logic rdy, input logic fl, input logic fz);
    alu_res_i   = alu;
    mem_data_i  = mem;
    dest_i      = dest;
    wb_en_i     = wb;
    mem_rd_en_i = rd;
    mem_ready_i = rdy;
    flush_i     = fl;
    freeze_i    = fz;
  endtask

  task automatic expect_wr(input logic [3:0] dest, input logic [31:0] value);
    wr_t e;
    e.dest  = dest;
    e.value = value;
    sb.push_back(e);
    exp_wr = 1'b1;
  endtask

  task automatic cycle(input string tag, input logic exp_stall);
    wr_t e;
    #1;
    chk({tag, ".stall"}, 32'(stall_o), 32'(exp_stall));
    @(posedge clk);
    #1;
    chk({tag, ".wb_en"}, 32'(wb_en_o), 32'(exp_wr));
    if (wb_en_o === 1'b1) begin
      chk({tag, ".pending"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, ".dest"}, 32'(wb_dest_o), 32'(e.dest));
        chk({tag, ".value"}, wb_value_o, e.value);
      end
    end
    exp_wr = 1'b0;
  endtask

  initial begin
    drive(32'h1234_0000, 32'h5678_0000, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.stall", 32'(stall_o), 32'd0);
    chk("rst.wb_en", 32'(wb_en_o), 32'd0);
    chk("rst.dest", 32'(wb_dest_o), 32'd0);
    chk("rst.value", wb_value_o, 32'd0);
    chk("rst.timeout", 32'(mem_timeout_o), 32'd0);
    drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    drive(32'h0000_00A5, 32'h0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_wr(4'd3, 32'h0000_00A5);
    cycle("alu", 1'b0);

    drive(32'h0000_1111, 32'hDEAD_BEEF, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_wr(4'd7, 32'hDEAD_BEEF);
    cycle("ld0", 1'b0);

    drive(32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("idle", 1'b0);

    drive(32'h5555_0000, 32'hBAD0_0001, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("ld3.c1", 1'b1);
    mem_data_i = 32'hBAD0_0002;
    cycle("ld3.c2", 1'b1);
    cycle("ld3.c3", 1'b1);
    mem_ready_i = 1'b1;
    mem_data_i  = 32'h1234_5678;
    expect_wr(4'd5, 32'h1234_5678);
    cycle("ld3.rdy", 1'b0);

    drive(32'h0, 32'h0000_AAAA, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("fl.c1", 1'b1);
    flush_i     = 1'b1;
    mem_ready_i = 1'b1;
    cycle("fl.rdy", 1'b0);
    drive(32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("fl.after", 1'b0);
    drive(32'h0000_0042, 32'h0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_wr(4'd2, 32'h0000_0042);
    cycle("fl.alu", 1'b0);

    drive(32'h0, 32'h0000_0F0F, 4'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("fz.c1", 1'b1);
    freeze_i    = 1'b1;
    mem_ready_i = 1'b1;
    mem_data_i  = 32'hCAFE_F00D;
    cycle("fz.hold", 1'b1);
    freeze_i = 1'b0;
    expect_wr(4'd10, 32'hCAFE_F00D);
    cycle("fz.rdy", 1'b0);

    drive(32'h0000_0077, 32'h0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("flidle", 1'b0);
    drive(32'h0000_0088, 32'h0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("fzidle", 1'b0);

    drive(32'h0000_0001, 32'hBBBB_0000, 4'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      cycle($sformatf("to.%0d", k), 1'b1);
      chk($sformatf("to.%0d.flag", k), 32'(mem_timeout_o), 32'(k >= 15));
    end
    mem_ready_i = 1'b1;
    mem_data_i  = 32'h0000_600D;
    expect_wr(4'd12, 32'h0000_600D);
    cycle("to.rdy", 1'b0);
    chk("to.sticky", 32'(mem_timeout_o), 32'd1);

    drive(32'h0, 32'h9999_9999, 4'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("rw.c1", 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("rw.stall", 32'(stall_o), 32'd0);
    chk("rw.wb_en", 32'(wb_en_o), 32'd0);
    chk("rw.dest", 32'(wb_dest_o), 32'd0);
    chk("rw.value", wb_value_o, 32'd0);
    chk("rw.timeout", 32'(mem_timeout_o), 32'd0);
    drive(32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive(32'h0BAD_CAFE, 32'h0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_wr(4'd1, 32'h0BAD_CAFE);
    cycle("rw.alu", 1'b0);

    chk("sb.drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
